// File: rtl/sr_cmd_gen_if.sv
// Request/drive bundle between the command generator and its neighbours:
// raw set/clear requests in, latch drives and status out.
interface sr_cmd_gen_if;
    logic set_raw;
    logic clr_raw;
    logic S;
    logic R;
    logic enb;
    logic busy;
    logic overflow;

    modport master (
        output set_raw, clr_raw,
        input  S, R, enb, busy, overflow
    );

    modport slave (
        input  set_raw, clr_raw,
        output S, R, enb, busy, overflow
    );
endinterface

// File: rtl/sr_cmd_gen.sv
// SR latch command generator: synchronise, debounce and edge-detect two raw
// requests, then serialise them into fixed-length S/R pulses with one pending slot.
module sr_cmd_gen_deb #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic req
);
    logic [1:0] sync;
    logic       deb;
    logic       deb_q;
    logic [7:0] cnt;

    // Level moves only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], raw};
            deb_q <= deb;
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign req = deb & ~deb_q;
endmodule

module sr_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter bit CLR_PRIORITY    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    sr_cmd_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE_SET, DRIVE_CLR, GAP} state_t;

    logic [1:0] raw_vec;
    logic [1:0] req;

    assign raw_vec = {bus.clr_raw, bus.set_raw};

    for (genvar i = 0; i < 2; i++) begin : g_in
        sr_cmd_gen_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_vec[i]),
            .req   (req[i])
        );
    end

    logic   req_set, req_clr, req_any, req_both, win_clr;
    state_t state;
    logic [3:0] pcnt;
    logic   pend_vld, pend_clr;
    logic   s_q, r_q, enb_q, busy_q, ovf_q;

    assign req_set  = req[0];
    assign req_clr  = req[1];
    assign req_any  = req_set | req_clr;
    assign req_both = req_set & req_clr;
    // Type of the request that wins this cycle (the only one, or the priority pick).
    assign win_clr  = req_both ? CLR_PRIORITY : req_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pcnt     <= '0;
            pend_vld <= 1'b0;
            pend_clr <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            enb_q    <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pcnt <= '0;
                    if (req_any) begin
                        state  <= win_clr ? DRIVE_CLR : DRIVE_SET;
                        s_q    <= ~win_clr;
                        r_q    <= win_clr;
                        enb_q  <= 1'b1;
                        busy_q <= 1'b1;
                        if (req_both) begin
                            if (!pend_vld) begin
                                pend_vld <= 1'b1;
                                pend_clr <= ~win_clr;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
                    end else if (pend_vld) begin
                        state    <= pend_clr ? DRIVE_CLR : DRIVE_SET;
                        s_q      <= ~pend_clr;
                        r_q      <= pend_clr;
                        enb_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        pend_vld <= 1'b0;
                    end
                end
                DRIVE_SET, DRIVE_CLR: begin
                    if (pcnt == 4'(PULSE_CYCLES - 1)) begin
                        state <= GAP;
                        pcnt  <= '0;
                        s_q   <= 1'b0;
                        r_q   <= 1'b0;
                        enb_q <= 1'b0;
                    end else begin
                        pcnt <= pcnt + 4'd1;
                    end
                end
                GAP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // While busy, one request fits in the slot; anything else is lost.
            if (state != IDLE && req_any) begin
                if (!pend_vld) begin
                    pend_vld <= 1'b1;
                    pend_clr <= win_clr;
                    if (req_both) ovf_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.enb      = enb_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: three parameterisations share one stimulus and are
// checked every cycle against a timeline model, plus hand-computed pins.
module tb_sr_cmd_gen;
    localparam int D = 4;
    localparam int PRIO [3] = '{1, 0, 1};
    localparam int PUL  [3] = '{2, 2, 12};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic set_raw = 1'b0;
    logic clr_raw = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sr_cmd_gen_if ba();
    sr_cmd_gen_if bb();
    sr_cmd_gen_if bc();
    assign ba.set_raw = set_raw;  assign ba.clr_raw = clr_raw;
    assign bb.set_raw = set_raw;  assign bb.clr_raw = clr_raw;
    assign bc.set_raw = set_raw;  assign bc.clr_raw = clr_raw;

    sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(2),  .CLR_PRIORITY(1'b1)) u_a (.clk(clk), .reset(reset), .bus(ba));
    sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(2),  .CLR_PRIORITY(1'b0)) u_b (.clk(clk), .reset(reset), .bus(bb));
    sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(12), .CLR_PRIORITY(1'b1)) u_c (.clk(clk), .reset(reset), .bus(bc));

    // {S, R, enb, busy, overflow}
    logic [4:0] obs [3];
    assign obs[0] = {ba.S, ba.R, ba.enb, ba.busy, ba.overflow};
    assign obs[1] = {bb.S, bb.R, bb.enb, bb.busy, bb.overflow};
    assign obs[2] = {bc.S, bc.R, bc.enb, bc.busy, bc.overflow};

    // Timeline model: edge numbers of each command start, not FSM states.
    int   en = 0;
    int   rst_e = 0;
    bit   raw_at [2][4];
    bit   deb [2];
    bit   rose [2];
    int   last_ok [2];
    int   st [3];
    int   free_e [3];
    bit   pv [3], pc [3], typ [3], ovf [3];
    logic [4:0] exp_o [3];

    initial begin
        for (int k = 0; k < 3; k++) exp_o[k] = '0;
        forever begin
            @(posedge clk);
            en++;
            if (reset) begin
                rst_e = en;
                for (int c = 0; c < 2; c++) begin
                    deb[c] = 0; rose[c] = 0; last_ok[c] = en;
                end
                for (int k = 0; k < 3; k++) begin
                    st[k] = -1000; free_e[k] = en + 1;
                    pv[k] = 0; pc[k] = 0; typ[k] = 0; ovf[k] = 0;
                end
            end else begin
                bit rs, rc, any, both, wc, syn;
                raw_at[0][en % 4] = set_raw;
                raw_at[1][en % 4] = clr_raw;
                rs = rose[0];
                rc = rose[1];
                // Level follows the synced input once it has disagreed for D edges.
                for (int c = 0; c < 2; c++) begin
                    syn = (en - 2 > rst_e) ? raw_at[c][(en - 2) % 4] : 1'b0;
                    rose[c] = 0;
                    if (syn == deb[c]) last_ok[c] = en;
                    else if (en - last_ok[c] >= D) begin
                        deb[c] = syn; last_ok[c] = en; rose[c] = syn;
                    end
                end
                any  = rs | rc;
                both = rs & rc;
                for (int k = 0; k < 3; k++) begin
                    wc = both ? (PRIO[k] != 0) : rc;
                    if (en >= free_e[k]) begin
                        if (any) begin
                            st[k] = en; typ[k] = wc; free_e[k] = en + PUL[k] + 2;
                            if (both) begin
                                if (!pv[k]) begin pv[k] = 1; pc[k] = !wc; end
                                else ovf[k] = 1;
                            end
                        end else if (pv[k]) begin
                            st[k] = en; typ[k] = pc[k]; free_e[k] = en + PUL[k] + 2; pv[k] = 0;
                        end
                    end else if (any) begin
                        if (!pv[k]) begin
                            pv[k] = 1; pc[k] = wc;
                            if (both) ovf[k] = 1;
                        end else ovf[k] = 1;
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                bit drv, bsy;
                drv = (en >= st[k]) && (en < st[k] + PUL[k]);
                bsy = (en >= st[k]) && (en <= st[k] + PUL[k]);
                exp_o[k] = {drv & ~typ[k], drv & typ[k], drv, bsy, ovf[k]};
            end
        end
    end

    // Per-cycle compare plus command counters for the directed pins.
    int   ncs [3] = '{0, 0, 0};
    int   ncr [3] = '{0, 0, 0};
    bit   prev_enb [3] = '{0, 0, 0};

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (obs[k] !== exp_o[k]) begin
                    fails++;
                    $display("FAIL model_cmp[%0d] t=%0t: got %b expected %b (S R enb busy ovf)", k, $time, obs[k], exp_o[k]);
                end
                tests++;
                if ((obs[k][4] & obs[k][3]) || ((obs[k][4] | obs[k][3]) & ~obs[k][2])) begin
                    fails++;
                    $display("FAIL invariant[%0d] t=%0t: got %b, S&R must be 0 and S|R needs enb", k, $time, obs[k]);
                end
                if (obs[k][2] && !prev_enb[k]) begin
                    if (obs[k][4]) ncs[k]++;
                    else ncr[k]++;
                end
                prev_enb[k] = obs[k][2];
            end
        end
    end

    task automatic lit(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int snap;
    int rl_s = 0;
    int rl_c = 0;

    initial begin
        step(3);
        reset = 1'b0;
        // Idle after reset
        step(20);
        lit("idle_cmds", ncs[0] + ncr[0] + ncs[1] + ncr[1] + ncs[2] + ncr[2], 0);
        lit("idle_out_a", int'(obs[0]), 0);

        // Single set: drive appears after the 7th edge, two cycles, then GAP
        set_raw = 1'b1;
        step(6);  lit("lat_pre_S", int'(obs[0][4]), 0);
        step(1);  lit("lat_drive1", int'(obs[0]), 5'b10110);
        step(1);  lit("lat_drive2", int'(obs[0]), 5'b10110);
        step(1);  lit("lat_gap", int'(obs[0]), 5'b00010);
        step(1);  lit("lat_idle", int'(obs[0]), 0);
        lit("set_cmds_1", ncs[0], 1);
        set_raw = 1'b0;
        step(30);

        // Short glitch, then a bounce train settling high
        set_raw = 1'b1; step(2); set_raw = 1'b0;
        step(15);
        lit("glitch_cmds", ncs[0], 1);
        set_raw = 1'b1; step(1); set_raw = 1'b0; step(1);
        set_raw = 1'b1; step(1); set_raw = 1'b0; step(1);
        set_raw = 1'b1;
        step(20);
        lit("bounce_cmds", ncs[0], 2);
        set_raw = 1'b0;
        step(30);

        // Simultaneous requests: order follows priority
        set_raw = 1'b1; clr_raw = 1'b1;
        step(7);
        lit("both_a_first", int'(obs[0]), 5'b01110);
        lit("both_b_first", int'(obs[1]), 5'b10110);
        step(4);
        lit("both_a_second", int'(obs[0]), 5'b10110);
        lit("both_b_second", int'(obs[1]), 5'b01110);
        step(4);
        set_raw = 1'b0; clr_raw = 1'b0;
        step(30);
        lit("both_a_ovf", int'(obs[0][0]), 0);
        lit("both_b_ovf", int'(obs[1][0]), 0);

        // Long pulse: clr queued, a second set dropped -> overflow
        set_raw = 1'b1;
        step(1); clr_raw = 1'b1;
        step(3); set_raw = 1'b0;
        step(4); set_raw = 1'b1;
        step(6); lit("drop_c_ovf_pre", int'(obs[2][0]), 0);
        step(1); lit("drop_c_ovf_set", int'(obs[2][0]), 1);
        step(6); lit("drop_c_clr_drive", int'(obs[2]), 5'b01111);
        lit("drop_a_ovf", int'(obs[0][0]), 0);
        set_raw = 1'b0; clr_raw = 1'b0;
        step(40);
        lit("drop_c_ovf_sticky", int'(obs[2][0]), 1);

        // Reset in the second drive cycle, with a clr waiting in the slot
        set_raw = 1'b1;
        step(1); clr_raw = 1'b1;
        step(7);
        lit("rst_mid_drive", int'(obs[0]), 5'b10110);
        snap = ncs[0] + ncr[0] + ncs[2] + ncr[2];
        reset = 1'b1; set_raw = 1'b0; clr_raw = 1'b0;
        step(1);
        lit("rst_a_out", int'(obs[0]), 0);
        lit("rst_c_out", int'(obs[2]), 0);
        step(1); reset = 1'b0;
        step(25);
        lit("rst_no_residual", ncs[0] + ncr[0] + ncs[2] + ncr[2], snap);

        // Random bouncy traffic with rare resets
        for (int n = 0; n < 3000; n++) begin
            if (rl_s == 0) begin set_raw = 1'($urandom_range(0, 1)); rl_s = $urandom_range(1, 12); end
            if (rl_c == 0) begin clr_raw = 1'($urandom_range(0, 1)); rl_c = $urandom_range(1, 12); end
            rl_s--; rl_c--;
            reset = ($urandom_range(0, 999) == 0);
            step(1);
        end
        reset = 1'b0; set_raw = 1'b0; clr_raw = 1'b0;
        step(40);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
